// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB3 register bank (CTRL/STATUS/TX FIFO/RX holding) with wait states and PSLVERR; optional byte strobes via APB_PSTRB_EN
module apb_reg_bank #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int TX_DEPTH    = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic [DATA_WIDTH-1:0]   ctrl_out,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   input  logic                    rx_valid,
   input  logic [15:0]             status_in
);
   localparam int AW = $clog2(TX_DEPTH);
   localparam int SW = DATA_WIDTH / 8;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [1:0] state, state_nxt;
   logic [3:0] cnt;
   logic setup_ph, access_ph, done;
   logic sel_ctrl, sel_stat, sel_tx, sel_rx, strb_ok, err, wr, rd;
   logic ctrl_we, push, pop, rx_rd, ovr_clr;
   logic [DATA_WIDTH-1:0] ctrl, hold, bmask;
   logic [AW:0] wptr, rptr, level;
   logic [DATA_WIDTH-1:0] mem [TX_DEPTH];
   logic tx_full, tx_empty, rx_full, rx_ovr;
   logic [31:0] status;

   // The state register holds the phase seen last cycle, so ACCESS is recognised in the very cycle PENABLE rises
   assign setup_ph  = PSEL & !PENABLE;
   assign access_ph = (state != IDLE) & PSEL & PENABLE;
   assign done      = access_ph & (cnt == WS);

   // Next phase: a SETUP always restarts, an unfinished ACCESS waits, anything else (including a dropped PSEL) idles
   always_comb begin
      state_nxt = setup_ph ? SETUP : (access_ph & !done) ? ACCESS : IDLE;
   end

   // Protocol state and wait counter
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (setup_ph) cnt <= '0;
         else if (access_ph & !done) cnt <= cnt + 4'd1;
      end
   end

   assign sel_ctrl = PADDR == ADDR_WIDTH'(0);
   assign sel_stat = PADDR == ADDR_WIDTH'(4);
   assign sel_tx   = PADDR == ADDR_WIDTH'(8);
   assign sel_rx   = PADDR == ADDR_WIDTH'(12);

`ifdef APB_PSTRB_EN
   assign strb_ok = &PSTRB;
   // Expand byte strobes into a bit mask for CTRL writes
   always_comb begin
      bmask = '0;
      for (int i = 0; i < SW; i++) bmask[i*8 +: 8] = {8{PSTRB[i]}};
   end
`else
   assign strb_ok = &(PSTRB | {SW{1'b1}});
   assign bmask   = '1;
`endif

   // Misaligned and unmapped addresses match no select and therefore error
   assign err = !(sel_ctrl | (sel_stat & !PWRITE) | (sel_rx & !PWRITE) | (sel_tx & PWRITE & !tx_full & strb_ok));
   assign wr  = done & !err & PWRITE;
   assign rd  = done & !err & !PWRITE;
   assign ctrl_we = wr & sel_ctrl;
   assign push    = wr & sel_tx;
   assign rx_rd   = rd & sel_rx;
   assign ovr_clr = ctrl_we & PWDATA[1] & bmask[1];

   assign level    = wptr - rptr;
   assign tx_full  = level == (AW+1)'(TX_DEPTH);
   assign tx_empty = level == '0;
   assign tx_valid = !tx_empty;
   assign tx_data  = tx_valid ? mem[rptr[AW-1:0]] : '0;
   assign pop      = tx_valid & tx_ready;

   assign status = {status_in, 8'(level), 4'b0, rx_ovr, rx_full, tx_empty, tx_full};

   assign PREADY   = done;
   assign PSLVERR  = done & err;
   assign PRDATA   = !rd ? '0 : sel_ctrl ? ctrl : sel_stat ? DATA_WIDTH'(status) : sel_rx ? hold : '0;
   assign ctrl_out = ctrl;

   // CTRL register; bit1 is a command strobe and is never stored
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) ctrl <= '0;
      else if (ctrl_we) ctrl <= (ctrl & ~bmask) | (PWDATA & bmask & ~DATA_WIDTH'(2));
   end

   // FIFO pointers; push and pop are independent so a simultaneous pair leaves the level unchanged
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
      end
   end

   // FIFO storage; contents are only observable through tx_data, which is gated by tx_valid
   always_ff @(posedge PCLK) begin
      if (push) mem[wptr[AW-1:0]] <= PWDATA;
   end

   // RX holding register: a new word wins over a same-cycle read, and only counts as overrun if nobody read
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         hold    <= '0;
         rx_full <= 1'b0;
         rx_ovr  <= 1'b0;
      end else begin
         if (rx_valid) begin
            hold    <= rx_data;
            rx_full <= 1'b1;
         end else if (rx_rd) begin
            rx_full <= 1'b0;
         end
         if (rx_valid & rx_full & !rx_rd) rx_ovr <= 1'b1;
         else if (ovr_clr) rx_ovr <= 1'b0;
      end
   end
endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

Parametrised APB3 slave register bank that connects the APB bus to a serial-style peripheral core. It provides a control register, a status register, a transmit FIFO and a receive holding register. It also supports configurable wait-state insertion and PSLVERR error reporting. It sits between the APB interconnect and the peripheral engine, replacing the fixed 4-bit/32-bit, zero-wait, error-free register slave.

## Interface
- ADDR_WIDTH, 8, PADDR width; byte address; ≥4.
- DATA_WIDTH, 32, PWDATA/PRDATA width; ≥32, multiple of 8.
- TX_DEPTH, 4, transmit FIFO entries; power of two, ≥2.
- WAIT_STATES, 0, extra ACCESS cycles before PREADY rises; 0–15.

Ports:
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte strobes (used only with APB_PSTRB_EN).
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completes.
- PSLVERR  out  1  transfer error, valid with PREADY.
- ctrl_out  out  DATA_WIDTH  CTRL register contents.
- tx_data  out  DATA_WIDTH  FIFO head.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  core pops head when tx_valid & tx_ready.
- rx_data  in  DATA_WIDTH  received word.
- rx_valid  in  1  one-cycle strobe; loads rx_data.
- status_in  in  16  core status, mirrored in STATUS[31:16].

## Operation
- Register map (word-aligned):
  - 0x00 CTRL, RW. Bit1 is write-1 self-clearing: it clears the overrun flag and always reads 0.
  - 0x04 STATUS, RO. Bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_overrun, [15:8] tx level, [31:16] status_in.
  - 0x08 TXDATA, WO. A write pushes PWDATA into the FIFO.
  - 0x0C RXDATA, RO. A read returns the holding register and clears rx_full.
- PSLVERR=1, with no state change, on any of:
  - PADDR[1:0]≠0
  - unmapped address
  - write to STATUS or RXDATA
  - read of TXDATA (PRDATA=0)
  - TXDATA write while tx_full
- Reading RXDATA while rx_full=0 returns the stale holding value with PSLVERR=0.
- Protocol FSM: IDLE → SETUP (PSEL & !PENABLE) → ACCESS (PSEL & PENABLE) → IDLE or SETUP on completion.
  - PSEL dropping in ACCESS returns to IDLE with no side effects.
  - PENABLE without a prior SETUP is ignored (PREADY=0).
- Wait counter clears in SETUP and increments each ACCESS cycle up to WAIT_STATES.
- Completion cycle: ACCESS & count==WAIT_STATES. All register side effects occur on the PCLK edge ending the completion cycle.
- TX FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(TX_DEPTH); pointers wrap.
  - tx_full when level==TX_DEPTH; tx_empty when level==0.
  - Core pop and APB push in the same cycle are both honoured; level is unchanged.
  - Fullness is evaluated before the same-cycle pop, so a push to a full FIFO errors even if a pop occurs.
- RX holding register:
  - rx_valid loads rx_data and sets rx_full.
  - If rx_full is already 1, the register is overwritten and rx_overrun is set (sticky).
  - If rx_valid coincides with an RXDATA read, the read returns the old value and rx_full stays 1 with the new data; no overrun.

## Timing
- PREADY, PSLVERR and PRDATA are combinational from the registered FSM/counter and the address decode.
  - They are asserted only in the completion cycle; PRDATA and PSLVERR are 0 otherwise.
- Transfer length is 2+WAIT_STATES cycles (SETUP plus ACCESS cycles).
- Back-to-back transfers are supported: SETUP can directly follow completion.
- Reset values:
  - PREADY=0, PSLVERR=0, PRDATA=0
  - CTRL=0, ctrl_out=0
  - FIFO empty (tx_valid=0, tx_data=0)
  - rx_full=0, rx_overrun=0, holding register=0
  - FSM in IDLE
- PRESET mid-transfer aborts the transfer immediately and discards FIFO contents.
- TXDATA write → tx_valid high on the next cycle; tx_data reflects the head the same cycle.
- rx_valid → STATUS.rx_full is visible to a read completing on the next cycle.

## Configuration
- APB_PSTRB_EN defined:
  - CTRL writes update only the bytes whose PSTRB bit is 1.
  - A TXDATA write with PSTRB not all-ones returns PSLVERR and does not push.
- APB_PSTRB_EN undefined: PSTRB is ignored and all writes are full-word.

## Test plan
- Reset, then read 0x04 with FIFO and RX idle → PRDATA=0x0000_0002 | status_in<<16, PSLVERR=0, PREADY in the 2nd cycle at WAIT_STATES=0.
- WAIT_STATES=3: write 0x00 with 0xA5 → PREADY low for 3 ACCESS cycles, high in the 4th; ctrl_out=0xA5 afterwards.
- TX_DEPTH=4, tx_ready=0:
  - Five TXDATA writes → the first four return PSLVERR=0 and tx level reads 4; the fifth returns PSLVERR=1.
  - Then tx_ready=1 for 4 cycles drains the FIFO in order with correct pointer wrap.
- Two rx_valid pulses with 0x11 then 0x22 and no read → RXDATA read returns 0x22 and STATUS.rx_overrun=1; writing CTRL bit1=1 clears it.
- Reads and writes to 0x10, 0x02 and a STATUS write → PSLVERR=1 and no register change.
- Assert PRESET during ACCESS with the FIFO holding 2 entries → PREADY=0, tx_valid=0 immediately, STATUS then reads tx_empty=1.
